// File: rtl/regfile_wb_queue_pkg.sv
// Shared constants and entry type for the register-file writeback queue.
//   WB_DEPTH   : default FIFO depth (power of two, >= 2)
//   DATA_W     : result width
//   ADDR_W     : register address width (2**ADDR_W registers)
//   wb_entry_t : one queued write {valid, rd, data}
package regfile_wb_queue_pkg;

   localparam int unsigned WB_DEPTH = 4;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned NREG     = 1 << ADDR_W;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Bundle of every non-clock signal of the writeback queue.
//   slave  : the queue side (consumes ALU/mult-div results and read addresses,
//            produces readies, register-file write strobe/enable/data, bypass, count)
//   master : the surrounding pipeline / register file side
interface regfile_wb_queue_if
   import regfile_wb_queue_pkg::*;
#(
   parameter int unsigned DEPTH = WB_DEPTH
);
   logic                      alu_valid;
   logic [ADDR_W-1:0]         alu_rd;
   logic [DATA_W-1:0]         alu_data;
   logic                      alu_ready;
   logic                      md_valid;
   logic [ADDR_W-1:0]         md_rd;
   logic [DATA_W-1:0]         md_data;
   logic                      md_ready;
   logic                      write_ctrl;
   logic [NREG-1:0]           wr_ie;
   logic [DATA_W-1:0]         wr_data;
   logic [ADDR_W-1:0]         rdA_addr;
   logic [ADDR_W-1:0]         rdB_addr;
   logic                      bypA_hit;
   logic [DATA_W-1:0]         bypA_data;
   logic                      bypB_hit;
   logic [DATA_W-1:0]         bypB_data;
   logic [$clog2(DEPTH):0]    count;

   modport slave (
      input  alu_valid, alu_rd, alu_data, md_valid, md_rd, md_data,
             rdA_addr, rdB_addr,
      output alu_ready, md_ready, write_ctrl, wr_ie, wr_data,
             bypA_hit, bypA_data, bypB_hit, bypB_data, count
   );

   modport master (
      output alu_valid, alu_rd, alu_data, md_valid, md_rd, md_data,
             rdA_addr, rdB_addr,
      input  alu_ready, md_ready, write_ctrl, wr_ie, wr_data,
             bypA_hit, bypA_data, bypB_hit, bypB_data, count
   );

endinterface

// File: rtl/wb_onehot_decoder.sv
// Address to one-hot decoder with enable; produces the per-register input enable.
//   en_i     : decode enable; all outputs 0 when low
//   addr_i   : register address
//   onehot_o : bit addr_i set when enabled
module wb_onehot_decoder #(
   parameter int unsigned AW = 5
) (
   input  logic                en_i,
   input  logic [AW-1:0]       addr_i,
   output logic [(1<<AW)-1:0]  onehot_o
);

   always_comb begin
      onehot_o = '0;
      if (en_i) onehot_o[addr_i] = 1'b1;
   end

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the register file. Merges ALU and mult/div results
// into a DEPTH-entry FIFO, drains one entry per cycle as a one-hot write enable,
// and offers the newest pending value per read port for bypass.
//   clk : rising-edge clock
//   clr : asynchronous active-high reset
//   wb  : handshake, drain, bypass and occupancy signals (slave side)
module regfile_wb_queue
   import regfile_wb_queue_pkg::*;
#(
   parameter int unsigned DEPTH = WB_DEPTH
) (
   input  logic                     clk,
   input  logic                     clr,
   regfile_wb_queue_if.slave        wb
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] FULL_C = (CNT_W+1)'(DEPTH);
   localparam logic [CNT_W:0] ONE_C  = (CNT_W+1)'(1);

   wb_entry_t          fifo_q [DEPTH];
   wb_entry_t          fifo_d [DEPTH];
   logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic               pop, alu_nz, md_nz, alu_enq, md_enq;
   logic [CNT_W:0]     free;
   logic [PTR_W-1:0]   idx;

   // The register file always accepts, so a non-empty queue pops every cycle and
   // that slot is already counted as free for this cycle's enqueue.
   always_comb begin
      pop          = (count_q != '0);
      free         = FULL_C - {1'b0, count_q} + {{CNT_W{1'b0}}, pop};
      alu_nz       = wb.alu_valid && (wb.alu_rd != '0);
      md_nz        = wb.md_valid && (wb.md_rd != '0);
      wb.alu_ready = (free >= ONE_C);
      // An r0 ALU write is dropped, so it does not take a slot from mult/div.
      wb.md_ready  = (free >= (ONE_C + {{CNT_W{1'b0}}, alu_nz}));
      alu_enq      = alu_nz && wb.alu_ready;
      md_enq       = md_nz && wb.md_ready;
   end

   // Pop clears the head first so that an enqueue into the same slot at full wins.
   always_comb begin
      fifo_d = fifo_q;
      head_d = head_q;
      if (pop) begin
         fifo_d[head_q].valid = 1'b0;
         head_d = head_q + PTR_W'(1);
      end
      if (alu_enq)
         fifo_d[tail_q] = '{valid: 1'b1, rd: wb.alu_rd, data: wb.alu_data};
      if (md_enq)
         fifo_d[tail_q + PTR_W'(alu_enq)] = '{valid: 1'b1, rd: wb.md_rd, data: wb.md_data};
      tail_d  = tail_q + PTR_W'(alu_enq) + PTR_W'(md_enq);
      count_d = count_q + CNT_W'(alu_enq) + CNT_W'(md_enq) - CNT_W'(pop);
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         fifo_q  <= fifo_d;
      end
   end

   always_comb begin
      wb.write_ctrl = pop;
      wb.wr_data    = pop ? fifo_q[head_q].data : '0;
      wb.count      = count_q;
   end

   wb_onehot_decoder #(.AW(ADDR_W)) u_dec (
      .en_i     (pop),
      .addr_i   (fifo_q[head_q].rd),
      .onehot_o (wb.wr_ie)
   );

   // Walk oldest to newest starting at head; a later match overwrites an earlier
   // one, leaving the newest. Valid bits mark exactly the occupied slots.
   always_comb begin
      wb.bypA_hit  = 1'b0;
      wb.bypA_data = '0;
      wb.bypB_hit  = 1'b0;
      wb.bypB_data = '0;
      idx          = head_q;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head_q + PTR_W'(i);
         if (fifo_q[idx].valid && (wb.rdA_addr != '0) && (fifo_q[idx].rd == wb.rdA_addr)) begin
            wb.bypA_hit  = 1'b1;
            wb.bypA_data = fifo_q[idx].data;
         end
         if (fifo_q[idx].valid && (wb.rdB_addr != '0) && (fifo_q[idx].rd == wb.rdB_addr)) begin
            wb.bypB_hit  = 1'b1;
            wb.bypB_data = fifo_q[idx].data;
         end
      end
   end

endmodule
